mem_access_arbiter: RTL and testbench

Single-port access controller for the byte-wide parameter memory (M entries × N bits, combinational read, write on rising clk when write_enable). Shares the one address/data port between a streaming loader (bytes arriving from the serial front-end, written to consecutive addresses) and a random-access reader (compute side). Arbitration is round-robin when both contend. Sits directly between the front-end/compute logic and the memory instance.

---
 rtl/mem_access_arbiter_pkg.sv | 18 +
 rtl/mem_access_arbiter_rr_arbiter2.sv | 42 ++++
 rtl/mem_access_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_access_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_arbiter_pkg.sv
// Shared types and defaults for the parameter-memory access arbiter.
// Holds the loader FSM states, the grant encoding and the default memory geometry.
package mem_access_arbiter_pkg;

    localparam int unsigned DEF_M = 164;
    localparam int unsigned DEF_N = 8;

    typedef enum logic {
        L_IDLE   = 1'b0,
        L_ACTIVE = 1'b1
    } load_state_t;

    typedef enum logic {
        GNT_WR = 1'b0,
        GNT_RD = 1'b1
    } gnt_t;

endpackage

// File: rtl/mem_access_arbiter_rr_arbiter2.sv
// Two-requester round-robin arbiter (writer vs reader) with its own last-grant register.
// Grants are combinational; the side not granted last wins a contended cycle.
module rr_arbiter2
    import mem_access_arbiter_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic wr_want,
    input  logic rd_want,
    output logic wr_gnt,
    output logic rd_gnt
);

    gnt_t last_gnt_q;

    always_comb begin
        wr_gnt = 1'b0;
        rd_gnt = 1'b0;
        if (wr_want && rd_want) begin
            if (last_gnt_q == GNT_RD) begin
                wr_gnt = 1'b1;
            end else begin
                rd_gnt = 1'b1;
            end
        end else begin
            wr_gnt = wr_want;
            rd_gnt = rd_want;
        end
    end

    // Reset to RD so the first contended cycle goes to the writer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_gnt_q <= GNT_RD;
        end else if (wr_gnt) begin
            last_gnt_q <= GNT_WR;
        end else if (rd_gnt) begin
            last_gnt_q <= GNT_RD;
        end
    end

endmodule

// File: rtl/mem_access_arbiter.sv
// Single-port access controller sharing the parameter memory between a streaming
// burst loader and a random-access reader, arbitrated round-robin.
module mem_access_arbiter
    import mem_access_arbiter_pkg::*;
#(
    parameter int unsigned M = DEF_M,
    parameter int unsigned N = DEF_N
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load_start,
    input  logic [$clog2(M)-1:0]     load_base,
    input  logic [$clog2(M+1)-1:0]   load_len,
    input  logic                     byte_valid,
    input  logic [N-1:0]             byte_data,
    output logic                     byte_ready,
    input  logic                     rd_req,
    input  logic [$clog2(M)-1:0]     rd_addr,
    output logic                     rd_gnt,
    output logic                     rd_valid,
    output logic [N-1:0]             rd_data,
    output logic                     load_busy,
    output logic                     load_done,
    output logic                     load_error,
    output logic [$clog2(M)-1:0]     mem_addr,
    output logic [N-1:0]             mem_data_in,
    output logic                     mem_write_enable,
    input  logic [N-1:0]             mem_data_out
);

    localparam int unsigned A  = $clog2(M);
    localparam int unsigned L  = $clog2(M + 1);
    localparam int unsigned LW = L + 1;

    load_state_t    state_q, state_d;
    logic [A-1:0]   base_q, base_d;
    logic [L-1:0]   len_q, len_d;
    logic [L-1:0]   count_q, count_d;
    logic           done_d, error_d;
    logic           wr_want, rd_want;
    logic           wr_gnt, arb_rd_gnt;
    logic [LW-1:0]  end_sum;
    logic [A-1:0]   wr_addr;

    assign wr_want = (state_q == L_ACTIVE) && byte_valid && !reset;
    assign rd_want = rd_req && !reset;
    assign end_sum = LW'(load_base) + LW'(load_len);
    assign wr_addr = base_q + A'(count_q);

    rr_arbiter2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .wr_want (wr_want),
        .rd_want (rd_want),
        .wr_gnt  (wr_gnt),
        .rd_gnt  (arb_rd_gnt)
    );

    // Memory port: write address when the loader wins, otherwise the reader's address.
    assign byte_ready       = wr_gnt;
    assign rd_gnt           = arb_rd_gnt;
    assign mem_write_enable = wr_gnt;
    assign mem_addr         = reset ? '0 : (wr_gnt ? wr_addr : rd_addr);
    assign mem_data_in      = reset ? '0 : byte_data;
    assign load_busy        = (state_q == L_ACTIVE);

    // Loader next-state: burst validation on start, counting on accepted bytes.
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        len_d   = len_q;
        count_d = count_q;
        done_d  = 1'b0;
        error_d = 1'b0;
        case (state_q)
            L_IDLE: begin
                if (load_start) begin
                    if (end_sum > LW'(M)) begin
                        error_d = 1'b1;
                    end else if (load_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        base_d  = load_base;
                        len_d   = load_len;
                        count_d = '0;
                        state_d = L_ACTIVE;
                    end
                end
            end
            L_ACTIVE: begin
                if (wr_gnt) begin
                    count_d = count_q + L'(1);
                    if (count_q == len_q - L'(1)) begin
                        state_d = L_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = L_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= L_IDLE;
            base_q     <= '0;
            len_q      <= '0;
            count_q    <= '0;
            load_done  <= 1'b0;
            load_error <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            len_q      <= len_d;
            count_q    <= count_d;
            load_done  <= done_d;
            load_error <= error_d;
        end
    end

    // Read data register: captures memory output on the grant cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= arb_rd_gnt;
            if (arb_rd_gnt) begin
                rd_data <= mem_data_out;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed bench for mem_access_arbiter with a behavioural memory model.
// Inputs change on the falling edge; outputs are sampled away from the rising edge.
module tb_mem_access_arbiter;

    localparam int unsigned M = 164;
    localparam int unsigned N = 8;
    localparam int unsigned A = $clog2(M);
    localparam int unsigned L = $clog2(M + 1);

    logic         clk;
    logic         reset;
    logic         load_start;
    logic [A-1:0] load_base;
    logic [L-1:0] load_len;
    logic         byte_valid;
    logic [N-1:0] byte_data;
    logic         byte_ready;
    logic         rd_req;
    logic [A-1:0] rd_addr;
    logic         rd_gnt;
    logic         rd_valid;
    logic [N-1:0] rd_data;
    logic         load_busy;
    logic         load_done;
    logic         load_error;
    logic [A-1:0] mem_addr;
    logic [N-1:0] mem_data_in;
    logic         mem_write_enable;
    logic [N-1:0] mem_data_out;

    logic [N-1:0] mem [M];

    int n_checks = 0;
    int n_errors = 0;

    mem_access_arbiter #(.M(M), .N(N)) dut (
        .clk              (clk),
        .reset            (reset),
        .load_start       (load_start),
        .load_base        (load_base),
        .load_len         (load_len),
        .byte_valid       (byte_valid),
        .byte_data        (byte_data),
        .byte_ready       (byte_ready),
        .rd_req           (rd_req),
        .rd_addr          (rd_addr),
        .rd_gnt           (rd_gnt),
        .rd_valid         (rd_valid),
        .rd_data          (rd_data),
        .load_busy        (load_busy),
        .load_done        (load_done),
        .load_error       (load_error),
        .mem_addr         (mem_addr),
        .mem_data_in      (mem_data_in),
        .mem_write_enable (mem_write_enable),
        .mem_data_out     (mem_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_write_enable && (int'(mem_addr) < M)) mem[mem_addr] <= mem_data_in;
    end
    assign mem_data_out = (int'(mem_addr) < M) ? mem[mem_addr] : '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic start_load(input logic [A-1:0] b, input logic [L-1:0] l);
        load_start = 1'b1;
        load_base  = b;
        load_len   = l;
        step();
        load_start = 1'b0;
    endtask

    task automatic wr_byte(input logic [A-1:0] addr, input logic [N-1:0] d);
        byte_valid = 1'b1;
        byte_data  = d;
        #1;
        check("wr_ready", 32'(byte_ready), 32'd1);
        check("wr_we", 32'(mem_write_enable), 32'd1);
        check("wr_addr", 32'(mem_addr), 32'(addr));
        check("wr_data", 32'(mem_data_in), 32'(d));
        step();
        byte_valid = 1'b0;
    endtask

    task automatic rd(input logic [A-1:0] addr, input logic [N-1:0] exp);
        rd_req  = 1'b1;
        rd_addr = addr;
        #1;
        check("rd_gnt", 32'(rd_gnt), 32'd1);
        check("rd_mem_addr", 32'(mem_addr), 32'(addr));
        check("rd_no_we", 32'(mem_write_enable), 32'd0);
        step();
        rd_req = 1'b0;
        check("rd_valid", 32'(rd_valid), 32'd1);
        check("rd_data", 32'(rd_data), 32'(exp));
    endtask

    initial begin
        for (int i = 0; i < int'(M); i++) mem[i] = '0;
        reset      = 1'b1;
        load_start = 1'b0;
        load_base  = '0;
        load_len   = '0;
        byte_valid = 1'b1;
        byte_data  = 8'h55;
        rd_req     = 1'b1;
        rd_addr    = 8'd5;
        #2;
        check("rst_byte_ready", 32'(byte_ready), 32'd0);
        check("rst_rd_gnt", 32'(rd_gnt), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_busy", 32'(load_busy), 32'd0);
        check("rst_done", 32'(load_done), 32'd0);
        check("rst_error", 32'(load_error), 32'd0);
        check("rst_we", 32'(mem_write_enable), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_data_in", 32'(mem_data_in), 32'd0);
        step();
        reset      = 1'b0;
        byte_valid = 1'b0;
        rd_req     = 1'b0;
        step();

        // Plain burst then readback
        start_load(8'd0, 8'd5);
        check("t1_busy", 32'(load_busy), 32'd1);
        for (int i = 0; i < 5; i++) wr_byte(8'(i), 8'(8'hA0 + i));
        check("t1_done", 32'(load_done), 32'd1);
        check("t1_busy_end", 32'(load_busy), 32'd0);
        step();
        check("t1_done_once", 32'(load_done), 32'd0);
        for (int i = 0; i < 5; i++) rd(8'(i), 8'(8'hA0 + i));
        step();
        check("t1_rd_valid_low", 32'(rd_valid), 32'd0);

        // Contention: strict alternation starting with the writer
        start_load(8'd11, 8'd5);
        rd_req     = 1'b1;
        rd_addr    = 8'd0;
        byte_valid = 1'b1;
        for (int c = 0; c < 9; c++) begin
            if (c > 0) begin
                check("t2_rd_valid", 32'(rd_valid), 32'((c - 1) % 2));
                if ((c - 1) % 2 == 1) check("t2_rd_data", 32'(rd_data), 32'hA0);
            end
            byte_data = 8'(8'hB0 + (c + 1) / 2);
            #1;
            check("t2_byte_ready", 32'(byte_ready), 32'(c % 2 == 0));
            check("t2_rd_gnt", 32'(rd_gnt), 32'(c % 2));
            if (c % 2 == 0) check("t2_wr_addr", 32'(mem_addr), 32'(11 + c / 2));
            step();
        end
        rd_req     = 1'b0;
        byte_valid = 1'b0;
        check("t2_done", 32'(load_done), 32'd1);
        check("t2_busy_end", 32'(load_busy), 32'd0);
        for (int i = 0; i < 5; i++) rd(8'(11 + i), 8'(8'hB0 + i));

        // Out-of-range burst rejected; exact-fit burst accepted
        byte_valid = 1'b1;
        byte_data  = 8'h77;
        start_load(8'd160, 8'd5);
        check("t3_error", 32'(load_error), 32'd1);
        check("t3_busy", 32'(load_busy), 32'd0);
        check("t3_no_we", 32'(mem_write_enable), 32'd0);
        step();
        check("t3_error_once", 32'(load_error), 32'd0);
        check("t3_no_we2", 32'(mem_write_enable), 32'd0);
        byte_valid = 1'b0;
        start_load(8'd159, 8'd5);
        check("t3_fit_no_error", 32'(load_error), 32'd0);
        check("t3_fit_busy", 32'(load_busy), 32'd1);
        for (int i = 0; i < 5; i++) wr_byte(8'(159 + i), 8'(8'hC0 + i));
        check("t3_fit_done", 32'(load_done), 32'd1);
        rd(8'd163, 8'hC4);

        // Zero-length burst, and start ignored while active
        start_load(8'd20, 8'd0);
        check("t4_zero_done", 32'(load_done), 32'd1);
        check("t4_zero_busy", 32'(load_busy), 32'd0);
        check("t4_zero_no_we", 32'(mem_write_enable), 32'd0);
        step();
        check("t4_zero_done_once", 32'(load_done), 32'd0);
        start_load(8'd30, 8'd3);
        wr_byte(8'd30, 8'h31);
        load_start = 1'b1;
        load_base  = 8'd50;
        load_len   = 8'd1;
        wr_byte(8'd31, 8'h32);
        load_start = 1'b0;
        check("t4_ignored_busy", 32'(load_busy), 32'd1);
        check("t4_ignored_no_done", 32'(load_done), 32'd0);
        wr_byte(8'd32, 8'h33);
        check("t4_done", 32'(load_done), 32'd1);

        // Sparse byte_valid: one byte every third cycle
        start_load(8'd40, 8'd3);
        for (int c = 0; c < 9; c++) begin
            if (c == 7) begin
                check("t5_done", 32'(load_done), 32'd1);
                check("t5_busy_end", 32'(load_busy), 32'd0);
            end
            byte_valid = (c % 3 == 0) && (c < 7);
            byte_data  = 8'(8'h90 + c / 3);
            #1;
            check("t5_byte_ready", 32'(byte_ready), 32'(byte_valid));
            if (byte_valid) check("t5_wr_addr", 32'(mem_addr), 32'(40 + c / 3));
            step();
        end
        byte_valid = 1'b0;
        rd(8'd41, 8'h91);

        // Reset mid-burst, then a fresh burst; old bytes retained
        start_load(8'd0, 8'd5);
        wr_byte(8'd0, 8'hD0);
        wr_byte(8'd1, 8'hD1);
        byte_valid = 1'b1;
        byte_data  = 8'hD2;
        rd_req     = 1'b1;
        rd_addr    = 8'd3;
        reset      = 1'b1;
        #1;
        check("t6_busy", 32'(load_busy), 32'd0);
        check("t6_byte_ready", 32'(byte_ready), 32'd0);
        check("t6_rd_gnt", 32'(rd_gnt), 32'd0);
        check("t6_we", 32'(mem_write_enable), 32'd0);
        check("t6_mem_addr", 32'(mem_addr), 32'd0);
        check("t6_mem_data_in", 32'(mem_data_in), 32'd0);
        check("t6_rd_data", 32'(rd_data), 32'd0);
        check("t6_rd_valid", 32'(rd_valid), 32'd0);
        step();
        reset      = 1'b0;
        byte_valid = 1'b0;
        rd_req     = 1'b0;
        step();
        check("t6_idle", 32'(load_busy), 32'd0);
        start_load(8'd0, 8'd1);
        wr_byte(8'd0, 8'hC0);
        check("t6_done", 32'(load_done), 32'd1);
        rd(8'd0, 8'hC0);
        rd(8'd1, 8'hD1);
        rd(8'd2, 8'hA2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
